// File: rtl/msg_decoder.sv
// msg_decoder: recovers a 64-byte LFSR-encrypted message from data memory.
//   The block reads a 10-byte header to identify which of nine fixed tap
//   patterns produced the key stream. It then decrypts all 64 bytes, strips
//   leading spaces, and writes the text to addresses 0..63, padding the
//   tail with spaces.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      synchronous, active-low reset
//   Start      run request (accepted in IDLE and DONE)
//   Ack        run complete (high in DONE)
//   RdAddr     read address; RdData is valid one cycle later
//   RdData     read data
//   WrEn       write enable; memory writes on the Clk edge where WrEn=1
//   WrAddr     write address (always < 64 when WrEn=1)
//   WrData     write data
//   DetPtrn    index 0..8 of the detected tap pattern
//   PreLen     number of leading spaces stripped
//   ParErrCnt  parity failures seen while decoding (saturating)
//   KeyErr     no usable key stream was found
module msg_decoder #(
    parameter int unsigned BASE = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] RdAddr,
    input  logic [7:0] RdData,
    output logic       WrEn,
    output logic [7:0] WrAddr,
    output logic [7:0] WrData,
    output logic [3:0] DetPtrn,
    output logic [6:0] PreLen,
    output logic [6:0] ParErrCnt,
    output logic       KeyErr
);

    localparam logic [7:0] BASE_ADDR = BASE[7:0];
    localparam logic [6:0] SPACE     = 7'h20;

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECODE, FILL, DONE} state_t;

    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        case (idx)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
        lfsr_step = {s[5:0], ^(s & taps)};
    endfunction

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic [6:0] hdr_q [10];
    logic [6:0] hdr_d [10];
    logic [6:0] lfsr_q, lfsr_d;
    logic [3:0] det_ptrn_q, det_ptrn_d;
    logic [6:0] pre_len_q, pre_len_d;
    logic [6:0] par_err_q, par_err_d;
    logic       key_err_q, key_err_d;
    logic [6:0] wr_ptr_q, wr_ptr_d;
    logic       seen_q, seen_d;

    logic [6:0] s0;
    logic [6:0] srch_s;
    logic       search_hit;
    logic       dec_valid;
    logic [6:0] dec_pt;
    logic       dec_strip;
    logic       dec_perr;
    logic       wr_en;

    // Header byte 0 is always a preamble space, so the key stream starts
    // at its ciphertext XOR 0x20.
    assign s0 = hdr_q[0] ^ SPACE;

    // Evaluate the candidate pattern indexed by cnt_q against header bytes 1..9.
    always_comb begin
        srch_s     = s0;
        search_hit = 1'b1;
        for (int unsigned k = 1; k < 10; k++) begin
            srch_s = lfsr_step(srch_s, tap_of(cnt_q[3:0]));
            if (srch_s != (hdr_q[k] ^ SPACE)) begin
                search_hit = 1'b0;
            end
        end
    end

    // Data for the byte issued last cycle arrives whenever cnt_q is non-zero.
    assign dec_valid = (state_q == DECODE) && (cnt_q != 7'd0);
    assign dec_pt    = RdData[6:0] ^ lfsr_q;
    assign dec_strip = !seen_q && (dec_pt == SPACE);
    assign dec_perr  = RdData[7] ^ (^RdData[6:0]);

    assign wr_en     = (dec_valid && !dec_strip) || (state_q == FILL);
    assign WrEn      = wr_en;
    assign WrAddr    = wr_en ? {2'b00, wr_ptr_q[5:0]} : '0;
    assign WrData    = !wr_en ? '0 : (state_q == FILL) ? {1'b0, SPACE} : {1'b0, dec_pt};

    assign Ack       = (state_q == DONE);
    assign RdAddr    = rd_addr_q;
    assign DetPtrn   = det_ptrn_q;
    assign PreLen    = pre_len_q;
    assign ParErrCnt = par_err_q;
    assign KeyErr    = key_err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_addr_d  = rd_addr_q;
        hdr_d      = hdr_q;
        lfsr_d     = lfsr_q;
        det_ptrn_d = det_ptrn_q;
        pre_len_d  = pre_len_q;
        par_err_d  = par_err_q;
        key_err_d  = key_err_q;
        wr_ptr_d   = wr_ptr_q;
        seen_d     = seen_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d   = LOAD;
                    cnt_d     = '0;
                    rd_addr_d = BASE_ADDR;
                    pre_len_d = '0;
                    par_err_d = '0;
                    key_err_d = 1'b0;
                end
            end

            LOAD: begin
                if (cnt_q != 7'd0) begin
                    hdr_d[cnt_q[3:0] - 4'd1] = RdData[6:0];
                end
                if (cnt_q < 7'd9) begin
                    rd_addr_d = rd_addr_q + 8'd1;
                end
                if (cnt_q == 7'd10) begin
                    cnt_d = '0;
                    if (s0 == 7'd0) begin
                        key_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = SEARCH;
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end

            SEARCH: begin
                if (search_hit) begin
                    det_ptrn_d = cnt_q[3:0];
                    lfsr_d     = s0;
                    cnt_d      = '0;
                    rd_addr_d  = BASE_ADDR;
                    wr_ptr_d   = '0;
                    seen_d     = 1'b0;
                    state_d    = DECODE;
                end else if (cnt_q == 7'd8) begin
                    key_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end

            DECODE: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q < 7'd63) begin
                    rd_addr_d = rd_addr_q + 8'd1;
                end
                if (dec_valid) begin
                    lfsr_d = lfsr_step(lfsr_q, tap_of(det_ptrn_q));
                    if (dec_perr && (par_err_q != 7'h7F)) begin
                        par_err_d = par_err_q + 7'd1;
                    end
                    if (dec_strip) begin
                        pre_len_d = pre_len_q + 7'd1;
                    end else begin
                        seen_d   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 7'd1;
                    end
                end
                if (cnt_q == 7'd64) begin
                    state_d = wr_ptr_d[6] ? DONE : FILL;
                end
            end

            FILL: begin
                wr_ptr_d = wr_ptr_q + 7'd1;
                if (wr_ptr_q[5:0] == 6'h3F) begin
                    state_d = DONE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            hdr_q      <= '{default: '0};
            lfsr_q     <= '0;
            det_ptrn_q <= '0;
            pre_len_q  <= '0;
            par_err_q  <= '0;
            key_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            hdr_q      <= hdr_d;
            lfsr_q     <= lfsr_d;
            det_ptrn_q <= det_ptrn_d;
            pre_len_q  <= pre_len_d;
            par_err_q  <= par_err_d;
            key_err_q  <= key_err_d;
            wr_ptr_q   <= wr_ptr_d;
            seen_q     <= seen_d;
        end
    end

endmodule

// File: doc/msg_decoder.md
MSG_DECODER -- requirements
Module: msg_decoder

Interface
REQ-001 SHALL have ports: Clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: Reset  in  1  reset, synchronous and active-low (0 resets on the Clk edge).
REQ-003 SHALL have ports: Start  in  1  run request, sampled in IDLE/DONE.
REQ-004 SHALL have ports: Ack  out  1  run complete.
REQ-005 SHALL have ports: RdAddr  out  8  data-memory read address; RdData  in  8  read data, valid exactly 1 cycle after RdAddr.
REQ-006 SHALL have ports: WrEn  out  1; WrAddr  out  8; WrData  out  8  data-memory write port, written on the Clk edge where WrEn=1.
REQ-007 SHALL have ports: DetPtrn  out  4  detected tap-pattern index 0..8; PreLen  out  7  leading spaces stripped; ParErrCnt  out  7  parity failures; KeyErr  out  1  no pattern matched.
REQ-008 SHALL use parameter BASE, default 64, meaning the first address of the 64-byte encrypted message.

Function
REQ-009 SHALL hold the fixed tap table 0x60,0x48,0x78,0x72,0x6A,0x69,0x5C,0x7E,0x7B for indices 0..8.
REQ-010 SHALL advance the LFSR as next = {s[5:0], ^(s & taps)}.
REQ-011 SHALL treat input byte i (address BASE+i) as {parity, c[6:0]}, with plaintext = c ^ lfsr_i and lfsr_0 = c_0 ^ 0x20.
REQ-012 SHALL implement states IDLE, LOAD, SEARCH, DECODE, FILL, DONE.
REQ-013 IDLE->LOAD SHALL occur when Start=1; Start in LOAD..FILL SHALL be ignored.
REQ-014 LOAD SHALL read addresses BASE..BASE+9 on consecutive cycles and buffer the 10 bytes (11 cycles incl. read latency).
REQ-015 LOAD SHALL end with s0 = c_0[6:0]^0x20; s0=0 SHALL set KeyErr=1 and go to DONE with no writes.
REQ-016 SEARCH SHALL test one pattern per cycle in index order 0..8; a pattern matches iff its predicted lfsr_k equals c_k[6:0]^0x20 for all k=1..9.
REQ-017 SEARCH SHALL latch the first (lowest-index) match into DetPtrn and go to DECODE; no match after index 8 SHALL set KeyErr=1 and go to DONE with no writes.
REQ-018 DECODE SHALL read addresses BASE..BASE+63 at one byte per cycle, pipelined, with the LFSR restarted from s0.
REQ-019 For each decoded byte, DECODE SHALL increment ParErrCnt (saturating at 127) when c[7] != ^c[6:0].
REQ-020 DECODE SHALL strip bytes whose plaintext = 0x20 occurring before the first non-space byte, without writing them, and count them in PreLen.
REQ-021 DECODE SHALL write every other byte as {1'b0, plaintext} to consecutive addresses starting at 0.
REQ-022 Interior and trailing spaces after the first non-space byte SHALL be written.
REQ-023 FILL SHALL write 0x20 to the remaining addresses up to 63, one per cycle; exactly 64 writes SHALL occur to 0..63 per successful run.
REQ-024 If all 64 bytes are spaces, PreLen SHALL be 64 and FILL SHALL write 0x20 to 0..63.
REQ-025 DONE SHALL drive Ack=1 and hold DetPtrn, PreLen, ParErrCnt, KeyErr stable.
REQ-026 Start=1 in DONE SHALL clear Ack, PreLen, ParErrCnt, KeyErr next cycle and enter LOAD.
REQ-027 WrEn SHALL be 0 outside DECODE/FILL.
REQ-028 The block SHALL never write addresses >= BASE.
REQ-029 Total latency Start->Ack for a successful run SHALL be at most 11 + 9 + 65 + 64 + 2 cycles.

Reset
REQ-030 Reset=0 at a Clk edge SHALL force IDLE and set Ack=0, WrEn=0, RdAddr=0, WrAddr=0, WrData=0, DetPtrn=0, PreLen=0, ParErrCnt=0, KeyErr=0.
REQ-031 Reset asserted mid-run SHALL abort with no further writes after that edge; Start SHALL be ignored while Reset=0.

Verification
REQ-032 Scenario: "Mr. Watson, come here. I want to see you." (41 chars), taps 0x72, init 0x01, preamble 10, encrypted at 64..127 -> Ack=1, DetPtrn=3, PreLen=10, KeyErr=0, ParErrCnt=0, mem[0..40]=message, mem[41..63]=0x20.
REQ-033 Scenario: same message, taps 0x7B, init 0x7F, preamble 15 -> DetPtrn=8, PreLen=15, identical mem[0..63].
REQ-034 Scenario: REQ-032 image with bit 7 flipped at addresses 80 and 100 -> ParErrCnt=2, DetPtrn=3, mem contents unchanged.
REQ-035 Scenario: address 64 = 0x20 (s0=0) -> KeyErr=1, Ack=1, zero writes; 64..127 random not matching any pattern -> KeyErr=1, zero writes.
REQ-036 Scenario: Reset=0 during DECODE, then a new Start with the REQ-033 image -> no writes after the reset edge, second run fully correct.
REQ-037 Scenario: 64 encrypted spaces -> PreLen=64, mem[0..63]=0x20; back-to-back Start in DONE -> Ack low 1 cycle later, results recomputed.
